register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   Small multi-port register file for the datapath: NREGS registers of WIDTH bits.
//   One synchronous write port and two independent combinational read ports.
//   Operands read0/read1 feed the ALU/datapath; w is the write-back value.
//   One clock; reset is asynchronous and active-low.
// PARAMETERS
//   WIDTH  8  data width of each register and of every data port
//   NREGS  2  number of registers; select width SELW = clog2(NREGS), minimum 1
// PORTS
//   sysclk  in   1         system clock, rising-edge active
//   rst_n   in   1         asynchronous active-low reset
//   w       in   WIDTH     write data
//   rw      in   1         write enable (1 = write on next rising edge, 0 = read only)
//   wsel    in   SELW      write register index
//   rsel    in   2*SELW    read selects: rsel[SELW-1:0] -> read0, rsel[2*SELW-1:SELW] -> read1
//   read0   out  WIDTH     contents of register rsel[SELW-1:0]
//   read1   out  WIDTH     contents of register rsel[2*SELW-1:SELW]
// BEHAVIOUR
//   - Reset: rst_n=0 immediately clears all registers to 0, independent of sysclk.
//     read0 and read1 therefore show 0 while reset is held.
//   - Reset release is synchronous-safe: no write while rst_n=0.
//     The first write can occur on the first rising edge with rst_n=1.
//   - Write: on the rising edge of sysclk with rw=1, reg[wsel] <= w.
//     - Only the selected register changes; all others hold.
//     - rw=0: no register changes; w and wsel are don't-care.
//   - Read: purely combinational, zero-cycle latency.
//     - read0 = reg[rsel[SELW-1:0]], read1 = reg[rsel[2*SELW-1:SELW]].
//     - Output changes follow rsel changes within the same cycle.
//   - Read-during-write, same index: the read port shows the OLD value until the edge.
//     The new value is visible immediately after the edge. No write-through bypass.
//   - Both read ports may select the same register; both show identical data.
//   - Out-of-range index (NREGS not a power of 2):
//     - write is ignored;
//     - read returns 0.
//   - Reset asserted in the same cycle as a write: reset wins, register stays 0.
//   - X/Z on rw is treated as no write (simulation assertion flags it).
//   - No handshake and no state machine; the register array is the only state.
// TESTING
//   1. Reset: write 8'hA5 to both regs, assert rst_n=0 mid-cycle
//      -> read0=read1=8'h00 immediately, before the next edge.
//   2. Write reg0: rw=1, wsel=0, w=8'hFF, one edge; rsel=2'b01
//      -> read1=8'hFF, read0=8'h00.
//   3. Write reg1: rw=1, wsel=1, w=8'h3C, one edge; rsel=2'b01
//      -> read0=8'h3C, read1=8'hFF. Then rsel=2'b10 -> read0=8'hFF, read1=8'h3C.
//   4. Write disabled: rw=0, wsel=0, w=8'h00 for 3 edges
//      -> reg0 still 8'hFF; both ports with rsel=2'b00 read 8'hFF.
//   5. Read-during-write: rsel=2'b00, rw=1, wsel=0, w=8'h12
//      -> read0=8'hFF before the edge, 8'h12 after; reg1 unchanged at 8'h3C.
//   6. Back-to-back writes to alternating wsel on consecutive edges (8'h01, 8'h02)
//      -> reg0=8'h01, reg1=8'h02; no cross-corruption.

Source files
------------

// File: rtl/register_file.sv
// Small multi-port register file: NREGS x WIDTH storage, one synchronous write
// port and two independent combinational read ports with no write-through bypass.
module register_file #(
    parameter int WIDTH = 8,
    parameter int NREGS = 2,
    localparam int SELW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  w,
    input  logic              rw,
    input  logic [SELW-1:0]   wsel,
    input  logic [2*SELW-1:0] rsel,
    output logic [WIDTH-1:0]  read0,
    output logic [WIDTH-1:0]  read1
);

    logic [WIDTH-1:0] regs [NREGS];
    logic [SELW-1:0]  rsel0;
    logic [SELW-1:0]  rsel1;

    assign rsel0 = rsel[SELW-1:0];
    assign rsel1 = rsel[2*SELW-1:SELW];

    // An index matching no register (non-power-of-2 NREGS) writes nothing.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (rw) begin
            for (int i = 0; i < NREGS; i++) begin
                if (wsel == SELW'(i)) begin
                    regs[i] <= w;
                end
            end
        end
    end

    // Out-of-range read indices fall through to the zero default.
    always_comb begin
        read0 = '0;
        read1 = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rsel0 == SELW'(i)) begin
                read0 = regs[i];
            end
            if (rsel1 == SELW'(i)) begin
                read1 = regs[i];
            end
        end
    end

    always @(posedge sysclk) begin
        if (rst_n) begin
            assert (!$isunknown(rw));
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (WIDTH=8, NREGS=2).
module tb_register_file;

    logic       sysclk;
    logic       rst_n;
    logic [7:0] w;
    logic       rw;
    logic [0:0] wsel;
    logic [1:0] rsel;
    logic [7:0] read0;
    logic [7:0] read1;

    int total = 0;
    int bad   = 0;

    register_file #(.WIDTH(8), .NREGS(2)) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .w      (w),
        .rw     (rw),
        .wsel   (wsel),
        .rsel   (rsel),
        .read0  (read0),
        .read1  (read1)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge and settle away from it.
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rw    = 1'b0;
        wsel  = 1'b0;
        w     = 8'h00;
        rsel  = 2'b10;
        #2;
        chk("rst_init_r0", read0, 8'h00);
        chk("rst_init_r1", read1, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;

        // 1. load A5 into both registers, then reset mid-cycle
        rw = 1'b1; wsel = 1'b0; w = 8'hA5;
        tick();
        wsel = 1'b1;
        tick();
        rw = 1'b0;
        #1;
        chk("pre_rst_r0", read0, 8'hA5);
        chk("pre_rst_r1", read1, 8'hA5);
        @(negedge sysclk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_r0", read0, 8'h00);
        chk("async_rst_r1", read1, 8'h00);
        // a write requested while reset is held must not land
        rw = 1'b1; wsel = 1'b0; w = 8'h77;
        tick();
        chk("rst_wins_r0", read0, 8'h00);
        chk("rst_wins_r1", read1, 8'h00);
        rw = 1'b0;
        #2;
        rst_n = 1'b1;
        #2;

        // 2. write reg0
        rw = 1'b1; wsel = 1'b0; w = 8'hFF;
        tick();
        rw = 1'b0; rsel = 2'b01;
        #1;
        chk("wr0_read1", read1, 8'hFF);
        chk("wr0_read0", read0, 8'h00);

        // 3. write reg1
        rw = 1'b1; wsel = 1'b1; w = 8'h3C;
        tick();
        rw = 1'b0; rsel = 2'b01;
        #1;
        chk("wr1_read0", read0, 8'h3C);
        chk("wr1_read1", read1, 8'hFF);
        rsel = 2'b10;
        #1;
        chk("swap_read0", read0, 8'hFF);
        chk("swap_read1", read1, 8'h3C);

        // 4. write disabled for three edges
        rw = 1'b0; wsel = 1'b0; w = 8'h00;
        tick(); tick(); tick();
        rsel = 2'b00;
        #1;
        chk("nowr_read0", read0, 8'hFF);
        chk("nowr_read1", read1, 8'hFF);
        rsel = 2'b11;
        #1;
        chk("nowr_reg1", read0, 8'h3C);

        // 5. read during write to the same index
        rsel = 2'b00; rw = 1'b1; wsel = 1'b0; w = 8'h12;
        #1;
        chk("rdw_before", read0, 8'hFF);
        tick();
        rw = 1'b0;
        chk("rdw_after_r0", read0, 8'h12);
        chk("rdw_after_r1", read1, 8'h12);
        rsel = 2'b11;
        #1;
        chk("rdw_reg1", read1, 8'h3C);

        // 6. back-to-back alternating writes
        rw = 1'b1; wsel = 1'b0; w = 8'h01;
        tick();
        wsel = 1'b1; w = 8'h02;
        tick();
        rw = 1'b0;
        rsel = 2'b10;
        #1;
        chk("b2b_reg0", read0, 8'h01);
        chk("b2b_reg1", read1, 8'h02);
        rsel = 2'b01;
        #1;
        chk("b2b_swap0", read0, 8'h02);
        chk("b2b_swap1", read1, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
